perceptron_classifier: RTL

PERCEPTRON_CLASSIFIER -- requirements
Module: perceptron_classifier

---
 rtl/perceptron_classifier_pkg.sv | 26 ++
 rtl/perceptron_classifier_dot.sv | 33 +++
 rtl/perceptron_classifier.sv | 121 ++++++++++++
 3 files changed

// File: rtl/perceptron_classifier_pkg.sv
// Shared widths, label encodings and state type for the perceptron classifier
// and the trainer datapath.
package perceptron_classifier_pkg;

  localparam int FEAT_W   = 7;
  localparam int WGT_W    = 14;
  localparam int PROD_W   = 21;
  localparam int SLICE_HI = 17;
  localparam int SLICE_LO = 4;
  localparam int SUM_W    = SLICE_HI - SLICE_LO + 1;
  localparam int CNT_W    = 8;
  localparam int LBL_W    = 2;

  localparam logic [LBL_W-1:0] LBL_POS = 2'b01;
  localparam logic [LBL_W-1:0] LBL_NEG = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic [LBL_W-1:0] sign_to_label(input logic neg);
    return neg ? LBL_NEG : LBL_POS;
  endfunction

endpackage

// File: rtl/perceptron_classifier_dot.sv
// Dot product plus bias: two product slices, then a wrapping 14-bit sum.
// Purely combinational; the slice and sum halves can be split across a pipeline.
module perceptron_dot
  import perceptron_classifier_pkg::*;
(
  input  logic signed [FEAT_W-1:0] x1,
  input  logic signed [FEAT_W-1:0] x2,
  input  logic signed [WGT_W-1:0]  w1,
  input  logic signed [WGT_W-1:0]  w2,
  output logic signed [SUM_W-1:0]  p1,
  output logic signed [SUM_W-1:0]  p2,
  input  logic signed [SUM_W-1:0]  p1_sum,
  input  logic signed [SUM_W-1:0]  p2_sum,
  input  logic signed [WGT_W-1:0]  b,
  output logic signed [SUM_W-1:0]  s
);

  logic signed [PROD_W-1:0] m1;
  logic signed [PROD_W-1:0] m2;
  logic                     unused_bits;

  assign m1 = PROD_W'(x1) * PROD_W'(w1);
  assign m2 = PROD_W'(x2) * PROD_W'(w2);

  // Trainer format keeps only bits [17:4]; upper and lower bits are dropped.
  assign p1 = m1[SLICE_HI:SLICE_LO];
  assign p2 = m2[SLICE_HI:SLICE_LO];
  assign unused_bits = ^{m1[PROD_W-1:SLICE_HI+1], m1[SLICE_LO-1:0],
                         m2[PROD_W-1:SLICE_HI+1], m2[SLICE_LO-1:0]};

  assign s = p1_sum + p2_sum + b;

endmodule

// File: rtl/perceptron_classifier.sv
// Two-stage perceptron inference pipeline with valid/ready handshakes,
// weight loading only when drained, and saturating result/error counters.
module perceptron_classifier
  import perceptron_classifier_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_load,
  input  logic signed [WGT_W-1:0] w1in,
  input  logic signed [WGT_W-1:0] w2in,
  input  logic signed [WGT_W-1:0] bin,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [FEAT_W-1:0] x1in,
  input  logic signed [FEAT_W-1:0] x2in,
  input  logic signed [LBL_W-1:0] tin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [LBL_W-1:0] tout,
  output logic                    match,
  output logic [CNT_W-1:0]        sample_count,
  output logic [CNT_W-1:0]        err_count
);

  state_t state_q, state_d;

  logic signed [WGT_W-1:0] w1_q, w2_q, b_q;
  logic                    v1, v2;
  logic signed [SUM_W-1:0] p1_d, p2_d, p1_q, p2_q, s_d, s_q;
  logic                    t_neg_q;
  logic                    adv1, adv2, load_ok, accept, out_fire;
  logic                    tin_unused;

  assign tin_unused = tin[0];

  perceptron_dot u_dot (
    .x1     (x1in),
    .x2     (x2in),
    .w1     (w1_q),
    .w2     (w2_q),
    .p1     (p1_d),
    .p2     (p2_d),
    .p1_sum (p1_q),
    .p2_sum (p2_q),
    .b      (b_q),
    .s      (s_d)
  );

  always_comb begin
    state_d  = state_q;
    load_ok  = w_load && !v1 && !v2;
    adv2     = !v2 || out_ready;
    adv1     = !v1 || adv2;
    in_ready = (state_q == ST_RUN) && adv1 && !load_ok;
    accept   = in_valid && in_ready;
    out_fire = v2 && out_ready;
    if (load_ok) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w1_q <= '0;
      w2_q <= '0;
      b_q  <= '0;
    end else if (load_ok) begin
      w1_q <= w1in;
      w2_q <= w2in;
      b_q  <= bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      t_neg_q <= 1'b0;
    end else if (adv1) begin
      v1 <= accept;
      if (accept) begin
        p1_q    <= p1_d;
        p2_q    <= p2_d;
        t_neg_q <= tin[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      s_q   <= '0;
      match <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s_q   <= s_d;
        match <= ~(s_d[SUM_W-1] ^ t_neg_q);
      end
    end
  end

  assign out_valid = v2;
  assign tout      = sign_to_label(s_q[SUM_W-1]);

  // Load and output handshake are mutually exclusive: a load needs v2 low.
  always_ff @(posedge clk) begin
    if (rst || load_ok) begin
      sample_count <= '0;
      err_count    <= '0;
    end else if (out_fire) begin
      if (sample_count != '1) sample_count <= sample_count + 1'b1;
      if (!match && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule
